// File: rtl/mul_sequencer.sv
// Sequential unsigned shift-add multiplier: one SIZE-bit add per clock,
// SIZE steps per product, result held in a registered 2*SIZE-bit output.

module mul_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
endmodule

module mul_sequencer #(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);
  localparam int unsigned CW = $clog2(SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] m;
  logic [SIZE-1:0] p_hi;
  logic [SIZE-1:0] p_lo;
  logic [CW-1:0]   cnt;

  logic [SIZE-1:0]   addend_c;
  logic [SIZE-1:0]   sum_c;
  logic              carry_c;
  logic [2*SIZE-1:0] step_c;

  // Gating the addend makes the no-add case P_hi + 0 with carry 0.
  assign addend_c = p_lo[0] ? m : '0;

  mul_adder #(.W(SIZE)) u_add (
    .x    (p_hi),
    .y    (addend_c),
    .cin  (1'b0),
    .sum  (sum_c),
    .cout (carry_c)
  );

  assign step_c = {carry_c, sum_c, p_lo[SIZE-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (flush) begin
            state <= S_IDLE;
          end else if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            m     <= a;
            p_hi  <= '0;
            p_lo  <= b;
            cnt   <= CW'(SIZE-1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            {p_hi, p_lo} <= step_c;
            if (cnt == '0) begin
              product <= step_c;
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: SIZE=32 and SIZE=8 instances against a plain a*b model.

module tb_mul_sequencer;
  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        start8;
  logic        flush8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int errors;
  int checks;

  mul_sequencer #(.SIZE(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flush   (flush),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  mul_sequencer #(.SIZE(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .start   (start8),
    .flush   (flush8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the sample just after the accepting edge.
  task automatic launch(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge; optional noise on a/b/start.
  task automatic wait_done(input bit noise, output int busy_n, output int done_cyc, output bit got);
    busy_n = 0; done_cyc = 0; got = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (done) begin got = 1'b1; done_cyc = i; break; end
      if (busy) busy_n++;
      if (noise) begin
        a = $urandom; b = $urandom; start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
    checks++; if (product8 !== 16'd0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_dut8: got product=%h busy=%b expected 0/0", product8, busy8); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int bn, dc; bit got;
    launch(32'd500, 32'd450);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (bn !== 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 32", bn); end
    checks++; if (dc !== 33) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 33", dc); end
    checks++; if (product !== 64'd225000) begin errors++; $display("FAIL basic_product: got %0d expected 225000", product); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0/0", done, busy); end
    repeat (3) @(negedge clk);
    checks++; if (product !== 64'd225000) begin errors++; $display("FAIL basic_hold: got %0d expected 225000", product); end
  endtask

  task automatic test_corner;
    int bn, dc; bit got;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL corner_ones: got %h expected fffffffe00000001", product); end
    launch(32'd0, 32'hFFFF_FFFF);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd0) begin errors++; $display("FAIL corner_zero_a: got %h expected 0", product); end
    launch(32'hFFFF_FFFF, 32'd0);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd0) begin errors++; $display("FAIL corner_zero_b: got %h expected 0", product); end
  endtask

  task automatic test_random;
    int bn, dc; bit got;
    logic [31:0] aa, bb;
    logic [63:0] exp;
    for (int k = 0; k < 12; k++) begin
      aa = $urandom; bb = $urandom;
      if (k % 4 == 1) bb = bb & 32'h0000_00FF;
      exp = 64'(aa) * 64'(bb);
      launch(aa, bb);
      wait_done(1'b1, bn, dc, got);
      checks++;
      if (!got || product !== exp || dc !== 33) begin
        errors++; $display("FAIL random_%0d: got %h at cycle %0d expected %h at cycle 33", k, product, dc, exp);
      end
    end
  endtask

  task automatic test_ignore_start;
    int bn, dc, n; bit got;
    launch(32'd3, 32'd5);
    repeat (5) @(negedge clk);
    a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'd1; b = 32'd2;
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd15) begin errors++; $display("FAIL ignore_product: got %0d expected 15", product); end
    count_dones(40, n);
    checks++; if (n !== 0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got %0d extra dones busy=%b expected 0/0", n, busy); end
  endtask

  task automatic test_flush;
    int bn, dc, n; bit got;
    launch(32'd6, 32'd7);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd42) begin errors++; $display("FAIL flush_setup: got %0d expected 42", product); end
    launch(32'd9, 32'd9);
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_abort: got busy=%b done=%b expected 0/0", busy, done); end
    count_dones(40, n);
    checks++; if (n !== 0 || product !== 64'd42) begin errors++; $display("FAIL flush_hold: got dones=%0d product=%0d expected 0/42", n, product); end
  endtask

  task automatic test_flush_priority;
    int bn, dc, n; bit got;
    @(negedge clk);
    a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got busy=%b expected 0", busy); end
    launch(32'd2, 32'd2);
    wait_done(1'b0, bn, dc, got);
    a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL prio_done: got busy=%b done=%b expected 0/0", busy, done); end
    count_dones(40, n);
    checks++; if (n !== 0 || product !== 64'd4) begin errors++; $display("FAIL prio_hold: got dones=%0d product=%0d expected 0/4", n, product); end
  endtask

  task automatic test_back_to_back;
    int bn, dc; bit got;
    launch(32'd10, 32'd10);
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd100) begin errors++; $display("FAIL b2b_first: got %0d expected 100", product); end
    a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1/0", busy, done); end
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || dc !== 33 || product !== 64'd6) begin errors++; $display("FAIL b2b_second: got %0d at cycle %0d expected 6 at cycle 33", product, dc); end
  endtask

  task automatic test_reset_mid_run;
    int bn, dc, n; bit got;
    launch(32'd4, 32'd5);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (product !== 64'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset: got product=%0d busy=%b expected 0/0", product, busy); end
    @(negedge clk);
    reset = 1'b0;
    count_dones(50, n);
    checks++; if (n !== 0 || product !== 64'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_discard: got dones=%0d product=%0d busy=%b expected 0/0/0", n, product, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_edge: got busy=%b expected 1", busy); end
    wait_done(1'b0, bn, dc, got);
    checks++; if (!got || product !== 64'd143) begin errors++; $display("FAIL reset_after_op: got %0d expected 143", product); end
  endtask

  task automatic test_size8;
    logic [7:0]  aa, bb;
    logic [15:0] exp;
    int dc;
    for (int k = 0; k < 7; k++) begin
      aa = (k == 0) ? 8'hFF : 8'($urandom);
      bb = (k == 0) ? 8'hFF : 8'($urandom);
      exp = 16'(aa) * 16'(bb);
      @(negedge clk);
      a8 = aa; b8 = bb; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      dc = 0;
      for (int i = 1; i <= 50; i++) begin
        if (done8) begin dc = i; break; end
        @(negedge clk);
      end
      checks++;
      if (dc !== 9 || product8 !== exp) begin
        errors++; $display("FAIL size8_%0d: got %h at cycle %0d expected %h at cycle 9", k, product8, dc, exp);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_corner();
    test_random();
    test_ignore_start();
    test_flush();
    test_flush_priority();
    test_back_to_back();
    test_reset_mid_run();
    test_size8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiplication.
REQ-005 SHALL have port flush  input  1  synchronous abort of an operation in progress.
REQ-006 SHALL have port a  input  SIZE  unsigned multiplicand.
REQ-007 SHALL have port b  input  SIZE  unsigned multiplier.
REQ-008 SHALL have port busy  output  1  high while an iteration sequence is running.
REQ-009 SHALL have port done  output  1  one-cycle pulse; product is valid.
REQ-010 SHALL have port product  output  2*SIZE  registered unsigned product a*b.

Function
REQ-011 SHALL perform unsigned shift-add multiplication using one instance of the team adder (SIZE bits, Cin tied 0, Cout used as the sum's MSB), one add per cycle.
REQ-012 SHALL implement states IDLE, RUN and DONE; encoding is free.
REQ-013 SHALL accept start only in IDLE or DONE, when flush is low; the accepting edge is E0.
REQ-014 At E0 SHALL capture a into the multiplicand register M, load P_hi=0 and P_lo=b, set iteration counter to SIZE-1 and enter RUN.
REQ-015 SHALL ignore a and b after E0; changes to them during RUN SHALL NOT affect the result.
REQ-016 Each RUN edge SHALL do one step: if P_lo[0]=1, {C,S}=P_hi+M, else {C,S}={0,P_hi}; then {P_hi,P_lo} <= {C,S,P_lo[SIZE-1:1]}.
REQ-017 The step at counter=0 SHALL be the last; steps occur on edges E1..E_SIZE.
REQ-018 At E_SIZE SHALL write {P_hi,P_lo} (post-step) to product and enter DONE.
REQ-019 done SHALL be high exactly for the one cycle the FSM is in DONE; busy SHALL be high exactly while in RUN.
REQ-020 From DONE with no start SHALL return to IDLE on the next edge; with start SHALL begin a new operation (back-to-back, no idle cycle).
REQ-021 start while in RUN SHALL be ignored and SHALL NOT queue.
REQ-022 flush high at an edge in RUN SHALL enter IDLE, leave product unchanged and produce no done.
REQ-023 flush high in IDLE or DONE SHALL force IDLE and SHALL take priority over start.
REQ-024 product SHALL hold its value from completion until the next completion or reset.
REQ-025 Latency SHALL be SIZE+1 cycles from E0 to done high; throughput one result per SIZE+1 cycles.
REQ-026 Operand zero or all-ones SHALL need no special casing; exact 2*SIZE-bit result, no overflow possible.

Reset
REQ-027 reset high SHALL immediately, independent of clk, force IDLE, busy=0, done=0, product=0, M/P_hi/P_lo/counter=0.
REQ-028 reset asserted mid-RUN SHALL discard the operation; no done SHALL follow after release.
REQ-029 After reset deassertion the block SHALL accept start at the first rising edge.

Verification
REQ-030 SIZE=32, a=500, b=450, start 1 cycle -> busy for 32 cycles, done at cycle 33 after E0, product=225000.
REQ-031 SIZE=32, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; then a=0, b=0xFFFFFFFF -> product=0.
REQ-032 start with a=3,b=5, start again mid-RUN with a=7,b=7, and a/b changed during RUN -> single done, product=15.
REQ-033 Run a=6,b=7 to done (42); start a=9,b=9, flush at cycle 10 -> busy drops next edge, no done, product stays 42.
REQ-034 start asserted during DONE cycle with a=2,b=3 -> next busy immediately, done SIZE+1 cycles later, product=6; reset pulse mid-RUN -> product=0, no done.
REQ-035 SIZE=8, a=255, b=255 -> done at cycle 9, product=0xFE01.
